// File: rtl/d_flip_flop_pkg.sv
// Shared defaults for the d_flip_flop register/delay primitive.
// Instantiators import these to keep WIDTH/DEPTH/RST_VAL consistent.

package d_flip_flop_pkg;

  localparam int unsigned DFF_WIDTH_DEF   = 1;
  localparam int unsigned DFF_DEPTH_DEF   = 1;
  localparam int unsigned DFF_RST_VAL_DEF = 0;

endpackage

// File: rtl/d_flip_flop_stage.sv
// Single WIDTH-bit register stage: async active-low reset to RST_VAL and a
// synchronous enable.

module d_flip_flop_stage
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned       WIDTH   = DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(DFF_RST_VAL_DEF)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (EN) begin
      data_d = D;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign Q = data_q;

endmodule

// File: rtl/d_flip_flop.sv
// DEPTH-stage D register with async active-low reset and clock enable.
// Define D_FLIP_FLOP_QN_EN to add the inverted output Q_N.

module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned       WIDTH   = DFF_WIDTH_DEF,
  parameter int unsigned       DEPTH   = DFF_DEPTH_DEF,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(DFF_RST_VAL_DEF)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
`ifdef D_FLIP_FLOP_QN_EN
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_N
`else
  output logic [WIDTH-1:0] Q
`endif
);

  // chain[0] is the input; chain[i+1] is the output of stage i.
  logic [DEPTH:0][WIDTH-1:0] chain;

  assign chain[0] = D;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    d_flip_flop_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (EN),
      .D     (chain[i]),
      .Q     (chain[i+1])
    );
  end

  assign Q = chain[DEPTH];

`ifdef D_FLIP_FLOP_QN_EN
  // Inverted straight off the last flop so Q_N shares Q's reset and timing.
  assign Q_N = ~chain[DEPTH];
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: single-bit, 8-bit enable and 3-deep pipeline
// instances driven by directed vectors; Q_N checked when D_FLIP_FLOP_QN_EN is set.

module tb_d_flip_flop;

  logic       clk;
  logic       rst_n;
  logic       en1, en8, enp;
  logic       d1, q1;
  logic [7:0] d8, q8;
  logic [7:0] dp, qp;
`ifdef D_FLIP_FLOP_QN_EN
  logic       qn1;
  logic [7:0] qn8, qnp;
`endif

  d_flip_flop #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_dff1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en1),
    .D     (d1),
`ifdef D_FLIP_FLOP_QN_EN
    .Q     (q1),
    .Q_N   (qn1)
`else
    .Q     (q1)
`endif
  );

  d_flip_flop #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_dff8 (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en8),
    .D     (d8),
`ifdef D_FLIP_FLOP_QN_EN
    .Q     (q8),
    .Q_N   (qn8)
`else
    .Q     (q8)
`endif
  );

  d_flip_flop #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u_pipe (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (enp),
    .D     (dp),
`ifdef D_FLIP_FLOP_QN_EN
    .Q     (qp),
    .Q_N   (qnp)
`else
    .Q     (qp)
`endif
  );

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } sb_rec_t;

  sb_rec_t sb_q[$];
  event    sample_ev;
  int      n_run  = 0;
  int      n_fail = 0;

  function automatic logic [7:0] observe(int sel);
    case (sel)
      0:       return {7'b0, q1};
      1:       return q8;
      2:       return qp;
`ifdef D_FLIP_FLOP_QN_EN
      3:       return {7'b0, qn1};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: drains every queued expectation each time outputs are presented.
  always begin
    @(sample_ev);
    while (sb_q.size() > 0) begin
      sb_rec_t    rec;
      logic [7:0] act;
      rec = sb_q.pop_front();
      act = observe(rec.sel);
      n_run++;
      if (act !== rec.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", rec.name, act, rec.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [7:0] exp);
    sb_rec_t rec;
    rec.name = name;
    rec.sel  = sel;
    rec.exp  = exp;
    sb_q.push_back(rec);
  endtask

  task automatic present();
    -> sample_ev;
    #1;
  endtask

  task automatic rise();
    #20 clk = 1'b1;
    #1;
  endtask

  task automatic fall();
    #19 clk = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    en1   = 1'b1;
    en8   = 1'b0;
    enp   = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;
    dp    = 8'h00;

    // Reset with clock idle takes effect immediately.
    #5 rst_n = 1'b0;
    #1;
    expect_val("rst_q1", 0, 8'h00);
    expect_val("rst_q8", 1, 8'h00);
    expect_val("rst_qp", 2, 8'h00);
`ifdef D_FLIP_FLOP_QN_EN
    expect_val("rst_qn1", 3, 8'h01);
`endif
    present();

    // Clock edges and data are ignored while reset is held.
    d1 = 1'b1;
    d8 = 8'hA5;
    dp = 8'hFF;
    en8 = 1'b1;
    enp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rise();
      expect_val("rst_hold_q1", 0, 8'h00);
      expect_val("rst_hold_q8", 1, 8'h00);
      expect_val("rst_hold_qp", 2, 8'h00);
      present();
      fall();
    end
    en8 = 1'b0;
    enp = 1'b0;

    // Release while clock low; first capture on the next rising edge.
    rst_n = 1'b1;
    rise();
    expect_val("cap_q1", 0, 8'h01);
    expect_val("en0_q8", 1, 8'h00);
`ifdef D_FLIP_FLOP_QN_EN
    expect_val("cap_qn1", 3, 8'h00);
`endif
    present();
    fall();

    // D change coincident with the edge: old value captured.
    #20 clk = 1'b1;
    #0 d1 = 1'b0;
    #1;
    expect_val("coincident_q1", 0, 8'h01);
    present();
    fall();
    rise();
    expect_val("next_edge_q1", 0, 8'h00);
    present();

    // Clock held high for two periods while D toggles.
    #19 d1 = 1'b1;
    #20 d1 = 1'b0;
    #20 d1 = 1'b1;
    #20 d1 = 1'b0;
    expect_val("level_q1", 0, 8'h00);
    present();
    clk = 1'b0;

    // Enable low: several edges, register holds.
    d8 = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      rise();
      fall();
    end
    expect_val("en0_hold_q8", 1, 8'h00);
    present();
    en8 = 1'b1;
    rise();
    expect_val("en1_q8", 1, 8'hA5);
    present();
    fall();
    en8 = 1'b0;
    d8  = 8'h3C;
    rise();
    expect_val("en0_keep_q8", 1, 8'hA5);
    present();
    fall();

    // 3-deep pipeline: latency of three enabled edges.
    enp = 1'b1;
    dp = 8'd1; rise(); expect_val("pipe_e1", 2, 8'd0); present(); fall();
    dp = 8'd2; rise(); expect_val("pipe_e2", 2, 8'd0); present(); fall();
    dp = 8'd3; rise(); expect_val("pipe_e3", 2, 8'd1); present(); fall();
    dp = 8'd4; rise(); expect_val("pipe_e4", 2, 8'd2); present(); fall();
    dp = 8'd5; rise(); expect_val("pipe_e5", 2, 8'd3); present(); fall();
    // Stall: whole pipeline freezes.
    enp = 1'b0;
    dp = 8'd9; rise(); expect_val("pipe_stall", 2, 8'd3); present(); fall();
    enp = 1'b1;
    dp = 8'd6; rise(); expect_val("pipe_resume", 2, 8'd4); present(); fall();

    // Reset mid-stream discards in-flight data without a clock.
    #5 rst_n = 1'b0;
    #1;
    expect_val("midrst_qp", 2, 8'd0);
    expect_val("midrst_q8", 1, 8'd0);
    present();
    #3 rst_n = 1'b1;
    dp = 8'd7; rise(); expect_val("post_rst_e1", 2, 8'd0); present(); fall();
    dp = 8'd8; rise(); expect_val("post_rst_e2", 2, 8'd0); present(); fall();
    rise(); expect_val("post_rst_e3", 2, 8'd7); present(); fall();

    #5;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
